// File: rtl/adc_tdm_rx_if.sv
// adc_tdm_rx_if: groups the converter-side serial lines and the receiver's
// sample/strobe/error outputs into one bundle.
//   master : converter side (drives BCLK/WCLK/LRCK/serialIn/errClr, observes results)
//   slave  : receiver side  (samples the serial lines, drives samples and flags)
// Parameters must match those of the adc_tdm_rx instance bound to it.
interface adc_tdm_rx_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     BCLK;
  logic                     WCLK;
  logic                     LRCK;
  logic                     serialIn;
  logic                     errClr;
  logic [NUM_CH*DATA_W-1:0] samplesOut;
  logic                     wordValid;
  logic [CH_W-1:0]          wordCh;
  logic                     frameValid;
  logic                     errLen;
  logic                     errOvr;

  modport master (
    output BCLK, WCLK, LRCK, serialIn, errClr,
    input  samplesOut, wordValid, wordCh, frameValid, errLen, errOvr
  );

  modport slave (
    input  BCLK, WCLK, LRCK, serialIn, errClr,
    output samplesOut, wordValid, wordCh, frameValid, errLen, errOvr
  );
endinterface

// File: rtl/adc_tdm_rx.sv
// adc_tdm_rx: oversampling serial ADC receiver (stereo or TDM).
// Synchronises BCLK/WCLK/LRCK/serialIn to clk, deserialises MSB-first words of
// DATA_W bits inside each WCLK window and steers them into NUM_CH slots counted
// from the LRCK rising edge.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus (slave)  : serial inputs, errClr; samplesOut (slot k at [k*DATA_W +: DATA_W]),
//                  wordValid/wordCh/frameValid strobes, sticky errLen/errOvr
module adc_tdm_rx #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
) (
  input logic         clk,
  input logic         reset_n,
  adc_tdm_rx_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SLOT_W = $clog2(NUM_CH + 1);
  localparam int CNT_W  = $clog2(DATA_W + 2);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(NUM_CH);
  localparam logic [CNT_W-1:0]  CNT_WORD  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DATA_W + 1);

  // Synchroniser bit order: {BCLK, WCLK, LRCK, serialIn}
  logic [3:0] sync1, sync2;
  logic       bclk_d;
  logic       bit_edge;
  logic       wclk_s, lrck_s, sd_s;

  logic [1:0]               state;
  logic                     wclk_q, lrck_q;
  logic [CNT_W-1:0]         bit_cnt;
  logic [DATA_W-1:0]        shreg;
  logic [SLOT_W-1:0]        slot_idx;
  logic                     frame_bad;
  logic [NUM_CH*DATA_W-1:0] samples;
  logic                     word_valid, frame_valid;
  logic [CH_W-1:0]          word_ch;
  logic                     err_len, err_ovr;

  logic lrck_rise, wclk_rise;

  assign wclk_s    = sync2[2];
  assign lrck_s    = sync2[1];
  assign sd_s      = sync2[0];
  assign bit_edge  = sync2[3] & ~bclk_d;
  assign lrck_rise = lrck_s & ~lrck_q;
  assign wclk_rise = wclk_s & ~wclk_q;

  // NOTE: every register below uses non-blocking assignment so all state
  // advances together on the clock edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      bclk_d <= 1'b0;
    end else begin
      sync1  <= {bus.BCLK, bus.WCLK, bus.LRCK, bus.serialIn};
      sync2  <= sync1;
      bclk_d <= sync2[3];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_UNSYNC;
      wclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      slot_idx    <= '0;
      frame_bad   <= 1'b0;
      // NOTE: the sample store is a set of output registers, not a RAM, and
      // must read zero out of reset, so it is reset with everything else.
      samples     <= '0;
      word_valid  <= 1'b0;
      frame_valid <= 1'b0;
      word_ch     <= '0;
      err_len     <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      frame_valid <= 1'b0;
      // Clear first; a set later in this block overrides it, so set wins.
      if (bus.errClr) begin
        err_len <= 1'b0;
        err_ovr <= 1'b0;
      end

      if (bit_edge) begin
        wclk_q <= wclk_s;
        lrck_q <= lrck_s;

        case (state)
          ST_UNSYNC: begin
            // Lock only on a frame start that falls outside a word window.
            if (lrck_rise && !wclk_s) begin
              state     <= ST_IDLE;
              slot_idx  <= '0;
              frame_bad <= 1'b0;
            end
          end

          ST_IDLE: begin
            if (lrck_rise) begin
              slot_idx  <= '0;
              frame_bad <= 1'b0;
            end
            if (wclk_rise) begin
              state   <= ST_SHIFT;
              shreg   <= {{(DATA_W-1){1'b0}}, sd_s};
              bit_cnt <= CNT_W'(1);
            end
          end

          ST_SHIFT: begin
            if (lrck_rise) begin
              // Frame restarted mid-word: the partial word is lost.
              slot_idx  <= '0;
              frame_bad <= 1'b0;
              err_len   <= 1'b1;
              if (wclk_s) begin
                shreg   <= {{(DATA_W-1){1'b0}}, sd_s};
                bit_cnt <= CNT_W'(1);
              end else begin
                state <= ST_IDLE;
              end
            end else if (wclk_s) begin
              shreg <= {shreg[DATA_W-2:0], sd_s};
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
              // Closing edge: its data bit is not part of the word.
              state <= ST_IDLE;
              if (bit_cnt != CNT_WORD) begin
                err_len   <= 1'b1;
                frame_bad <= 1'b1;
                // Holding at NUM_CH keeps later words in the overflow path.
                if (slot_idx != SLOT_FULL) slot_idx <= slot_idx + SLOT_W'(1);
              end else if (slot_idx == SLOT_FULL) begin
                err_ovr <= 1'b1;
              end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                  if (slot_idx == SLOT_W'(k)) samples[k*DATA_W +: DATA_W] <= shreg;
                end
                word_valid  <= 1'b1;
                word_ch     <= slot_idx[CH_W-1:0];
                frame_valid <= (slot_idx == SLOT_LAST) && !frame_bad;
                slot_idx    <= slot_idx + SLOT_W'(1);
              end
            end
          end

          default: state <= ST_UNSYNC;
        endcase
      end
    end
  end

  assign bus.samplesOut = samples;
  assign bus.wordValid  = word_valid;
  assign bus.wordCh     = word_ch;
  assign bus.frameValid = frame_valid;
  assign bus.errLen     = err_len;
  assign bus.errOvr     = err_ovr;
endmodule
